// File: rtl/hazard_ctrl_if.sv
// D-stage hazard query from the pipeline and the controller's stall/forward/busy answers.
interface hazard_ctrl_if;
  logic [4:0] rs_D;
  logic [4:0] rt_D;
  logic [1:0] Tuse_rs;
  logic [1:0] Tuse_rt;
  logic [4:0] A3_D;
  logic [1:0] Tnew_D;
  logic       md_start_D;
  logic       md_div_D;
  logic       md_use_D;
  logic       Stall;
  logic [1:0] fwd_rs_D;
  logic [1:0] fwd_rt_D;
  logic [1:0] fwd_rs_E;
  logic [1:0] fwd_rt_E;
  logic       md_busy;

  modport master (
    output rs_D, rt_D, Tuse_rs, Tuse_rt, A3_D, Tnew_D, md_start_D, md_div_D, md_use_D,
    input  Stall, fwd_rs_D, fwd_rt_D, fwd_rs_E, fwd_rt_E, md_busy
  );

  modport slave (
    input  rs_D, rt_D, Tuse_rs, Tuse_rt, A3_D, Tnew_D, md_start_D, md_div_D, md_use_D,
    output Stall, fwd_rs_D, fwd_rt_D, fwd_rs_E, fwd_rt_E, md_busy
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Stall/forwarding controller for the 5-stage MIPS core with a shadow E/M/W pipeline.
// Define HAZARD_MD_BUSY_EN to build the shared mult/div busy counter and its stall.
module hazard_ctrl #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic         clk,
  input  logic         reset,
  hazard_ctrl_if.slave hz
);
  localparam int unsigned REG_W = 5;
  localparam int unsigned T_W   = 2;
  localparam int unsigned CNT_W = 4;

  logic [REG_W-1:0] a3_e_q, a3_e_d, rs_e_q, rs_e_d, rt_e_q, rt_e_d;
  logic [REG_W-1:0] a3_m_q, a3_m_d, a3_w_q, a3_w_d;
  logic [T_W-1:0]   tnew_e_q, tnew_e_d, tnew_m_q, tnew_m_d;
  logic             data_stall_c, md_stall_c, md_busy_c, stall_c;

  // A source read at Tuse stalls while a producer's result is still Tnew cycles away.
  function automatic logic src_stall(input logic [REG_W-1:0] src, input logic [T_W-1:0] tuse,
                                     input logic [REG_W-1:0] a3_e, input logic [T_W-1:0] tnew_e,
                                     input logic [REG_W-1:0] a3_m, input logic [T_W-1:0] tnew_m);
    logic hit_e, hit_m;
    hit_e = (src == a3_e) && (tuse < tnew_e);
    hit_m = (src == a3_m) && (tuse < tnew_m);
    return (src != '0) && (hit_e || hit_m);
  endfunction

  function automatic logic [1:0] fwd_d(input logic [REG_W-1:0] src,
                                       input logic [REG_W-1:0] a3_e, input logic [T_W-1:0] tnew_e,
                                       input logic [REG_W-1:0] a3_m, input logic [T_W-1:0] tnew_m,
                                       input logic [REG_W-1:0] a3_w);
    logic [1:0] sel;
    sel = 2'd0;
    if (src != '0) begin
      if ((a3_e == src) && (tnew_e == '0))      sel = 2'd1;
      else if ((a3_m == src) && (tnew_m == '0)) sel = 2'd2;
      else if (a3_w == src)                     sel = 2'd3;
    end
    return sel;
  endfunction

  function automatic logic [1:0] fwd_e(input logic [REG_W-1:0] src,
                                       input logic [REG_W-1:0] a3_m, input logic [T_W-1:0] tnew_m,
                                       input logic [REG_W-1:0] a3_w);
    logic [1:0] sel;
    sel = 2'd0;
    if (src != '0) begin
      if ((a3_m == src) && (tnew_m == '0)) sel = 2'd2;
      else if (a3_w == src)                sel = 2'd3;
    end
    return sel;
  endfunction

  always_comb begin
    data_stall_c = src_stall(hz.rs_D, hz.Tuse_rs, a3_e_q, tnew_e_q, a3_m_q, tnew_m_q) |
                   src_stall(hz.rt_D, hz.Tuse_rt, a3_e_q, tnew_e_q, a3_m_q, tnew_m_q);
    stall_c      = data_stall_c | md_stall_c;
  end

  // A stall injects a bubble into E; M and W always advance.
  always_comb begin
    a3_e_d   = hz.A3_D;
    tnew_e_d = hz.Tnew_D;
    rs_e_d   = hz.rs_D;
    rt_e_d   = hz.rt_D;
    if (stall_c) begin
      a3_e_d   = '0;
      tnew_e_d = '0;
      rs_e_d   = '0;
      rt_e_d   = '0;
    end
    a3_m_d   = a3_e_q;
    tnew_m_d = (tnew_e_q == '0) ? '0 : tnew_e_q - T_W'(1);
    a3_w_d   = a3_m_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      a3_e_q   <= '0;
      tnew_e_q <= '0;
      rs_e_q   <= '0;
      rt_e_q   <= '0;
      a3_m_q   <= '0;
      tnew_m_q <= '0;
      a3_w_q   <= '0;
    end else begin
      a3_e_q   <= a3_e_d;
      tnew_e_q <= tnew_e_d;
      rs_e_q   <= rs_e_d;
      rt_e_q   <= rt_e_d;
      a3_m_q   <= a3_m_d;
      tnew_m_q <= tnew_m_d;
      a3_w_q   <= a3_w_d;
    end
  end

`ifdef HAZARD_MD_BUSY_EN
  logic             md_start_e_q, md_start_e_d, md_div_e_q, md_div_e_d;
  logic [CNT_W-1:0] md_cnt_q, md_cnt_d;

  // Counter loads as the op leaves E, then counts down the remaining busy cycles.
  always_comb begin
    md_start_e_d = stall_c ? 1'b0 : hz.md_start_D;
    md_div_e_d   = stall_c ? 1'b0 : hz.md_div_D;
    md_cnt_d     = md_cnt_q;
    if (md_start_e_q)          md_cnt_d = md_div_e_q ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
    else if (md_cnt_q != '0)   md_cnt_d = md_cnt_q - CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      md_start_e_q <= 1'b0;
      md_div_e_q   <= 1'b0;
      md_cnt_q     <= '0;
    end else begin
      md_start_e_q <= md_start_e_d;
      md_div_e_q   <= md_div_e_d;
      md_cnt_q     <= md_cnt_d;
    end
  end

  assign md_busy_c  = md_start_e_q | (md_cnt_q != '0);
  assign md_stall_c = hz.md_use_D & md_busy_c;
`else
  logic unused_md;
  assign unused_md  = ^{hz.md_start_D, hz.md_div_D, hz.md_use_D};
  assign md_busy_c  = 1'b0;
  assign md_stall_c = 1'b0;
`endif

  assign hz.Stall    = stall_c;
  assign hz.md_busy  = md_busy_c;
  assign hz.fwd_rs_D = fwd_d(hz.rs_D, a3_e_q, tnew_e_q, a3_m_q, tnew_m_q, a3_w_q);
  assign hz.fwd_rt_D = fwd_d(hz.rt_D, a3_e_q, tnew_e_q, a3_m_q, tnew_m_q, a3_w_q);
  assign hz.fwd_rs_E = fwd_e(rs_e_q, a3_m_q, tnew_m_q, a3_w_q);
  assign hz.fwd_rt_E = fwd_e(rt_e_q, a3_m_q, tnew_m_q, a3_w_q);
endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed scoreboard bench for hazard_ctrl; expectations follow HAZARD_MD_BUSY_EN.
module tb_hazard_ctrl;
`ifdef HAZARD_MD_BUSY_EN
  localparam bit MD_EN = 1'b1;
`else
  localparam bit MD_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  hazard_ctrl_if hif();

  hazard_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) u_dut (
    .clk   (clk),
    .reset (reset),
    .hz    (hif)
  );

  typedef struct {
    string      tag;
    logic       stall;
    logic [1:0] frs_d;
    logic [1:0] frt_d;
    logic [1:0] frs_e;
    logic [1:0] frt_e;
    logic       busy;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic cmp(input string tag, input logic [1:0] obs, input logic [1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [4:0] rs, input logic [4:0] rt,
                       input logic [1:0] tur, input logic [1:0] tut,
                       input logic [4:0] a3, input logic [1:0] tnew,
                       input logic ms, input logic md, input logic mu);
    hif.rs_D       = rs;
    hif.rt_D       = rt;
    hif.Tuse_rs    = tur;
    hif.Tuse_rt    = tut;
    hif.A3_D       = a3;
    hif.Tnew_D     = tnew;
    hif.md_start_D = ms;
    hif.md_div_D   = md;
    hif.md_use_D   = mu;
  endtask

  task automatic nop();
    drive(5'd0, 5'd0, 2'd3, 2'd3, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic expect_o(input string tag, input logic st, input logic [1:0] a, input logic [1:0] b,
                          input logic [1:0] c, input logic [1:0] d, input logic bz);
    exp_t e;
    e.tag = tag; e.stall = st; e.frs_d = a; e.frt_d = b; e.frs_e = c; e.frt_e = d; e.busy = bz;
    sb.push_back(e);
  endtask

  // Compare mid-cycle, then advance one clock and settle just past the edge.
  task automatic tick();
    exp_t e;
    #3;
    while (sb.size() != 0) begin
      e = sb.pop_front();
      cmp({e.tag, ".stall"},    {1'b0, hif.Stall},   {1'b0, e.stall});
      cmp({e.tag, ".fwd_rs_D"}, hif.fwd_rs_D,        e.frs_d);
      cmp({e.tag, ".fwd_rt_D"}, hif.fwd_rt_D,        e.frt_d);
      cmp({e.tag, ".fwd_rs_E"}, hif.fwd_rs_E,        e.frs_e);
      cmp({e.tag, ".fwd_rt_E"}, hif.fwd_rt_E,        e.frt_e);
      cmp({e.tag, ".md_busy"},  {1'b0, hif.md_busy}, {1'b0, e.busy});
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    drive(5'($urandom), 5'($urandom), 2'($urandom), 2'($urandom), 5'($urandom), 2'($urandom),
          1'($urandom), 1'($urandom), 1'($urandom));
    @(posedge clk);
    #1;
    drive(5'($urandom), 5'($urandom), 2'($urandom), 2'($urandom), 5'($urandom), 2'($urandom),
          1'($urandom), 1'($urandom), 1'($urandom));
    @(posedge clk);
    #1;
    reset = 1'b0;
    nop();
    expect_o("reset", 1'b0, 2'd0, 2'd0, 2'd0, 2'd0, 1'b0); tick();

    // addu $3 then beq $3: one stall, then forward from M, then beq in E takes W
    drive(5'd0, 5'd0, 2'd3, 2'd3, 5'd3, 2'd1, 1'b0, 1'b0, 1'b0);
    expect_o("addu_issue", 1'b0, 2'd0, 2'd0, 2'd0, 2'd0, 1'b0); tick();
    drive(5'd3, 5'd0, 2'd0, 2'd3, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0);
    expect_o("beq_stall", 1'b1, 2'd0, 2'd0, 2'd0, 2'd0, 1'b0); tick();
    expect_o("beq_fwd_m", 1'b0, 2'd2, 2'd0, 2'd0, 2'd0, 1'b0); tick();
    nop();
    expect_o("beq_e_fwd_w", 1'b0, 2'd0, 2'd0, 2'd3, 2'd0, 1'b0); tick();
    expect_o("flush1", 1'b0, 2'd0, 2'd0, 2'd0, 2'd0, 1'b0); tick();

    // lw $5 then addu rt=$5: single stall, ALU operand taken from W
    drive(5'd0, 5'd0, 2'd3, 2'd3, 5'd5, 2'd2, 1'b0, 1'b0, 1'b0);
    expect_o("lw_issue", 1'b0, 2'd0, 2'd0, 2'd0, 2'd0, 1'b0); tick();
    drive(5'd0, 5'd5, 2'd3, 2'd1, 5'd6, 2'd1, 1'b0, 1'b0, 1'b0);
    expect_o("ld_alu_stall", 1'b1, 2'd0, 2'd0, 2'd0, 2'd0, 1'b0); tick();
    expect_o("ld_alu_go", 1'b0, 2'd0, 2'd0, 2'd0, 2'd0, 1'b0); tick();
    nop();
    expect_o("ld_alu_fwd_w", 1'b0, 2'd0, 2'd0, 2'd0, 2'd3, 1'b0); tick();
    expect_o("flush2", 1'b0, 2'd0, 2'd0, 2'd0, 2'd0, 1'b0); tick();

    // lw $5 then beq $5: two stalls, then comparator forward from W
    drive(5'd0, 5'd0, 2'd3, 2'd3, 5'd5, 2'd2, 1'b0, 1'b0, 1'b0);
    expect_o("lw2_issue", 1'b0, 2'd0, 2'd0, 2'd0, 2'd0, 1'b0); tick();
    drive(5'd5, 5'd0, 2'd0, 2'd3, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0);
    expect_o("ld_beq_stall1", 1'b1, 2'd0, 2'd0, 2'd0, 2'd0, 1'b0); tick();
    expect_o("ld_beq_stall2", 1'b1, 2'd0, 2'd0, 2'd0, 2'd0, 1'b0); tick();
    expect_o("ld_beq_fwd_w", 1'b0, 2'd3, 2'd0, 2'd0, 2'd0, 1'b0); tick();
    nop();
    expect_o("flush3", 1'b0, 2'd0, 2'd0, 2'd0, 2'd0, 1'b0); tick();

    // jal then jr $31: no stall, PC8 forwarded from E, then from M into E
    drive(5'd0, 5'd0, 2'd3, 2'd3, 5'd31, 2'd0, 1'b0, 1'b0, 1'b0);
    expect_o("jal_issue", 1'b0, 2'd0, 2'd0, 2'd0, 2'd0, 1'b0); tick();
    drive(5'd31, 5'd0, 2'd0, 2'd3, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0);
    expect_o("jr_fwd_e", 1'b0, 2'd1, 2'd0, 2'd0, 2'd0, 1'b0); tick();
    nop();
    expect_o("jr_e_fwd_m", 1'b0, 2'd0, 2'd0, 2'd2, 2'd0, 1'b0); tick();
    expect_o("flush4", 1'b0, 2'd0, 2'd0, 2'd0, 2'd0, 1'b0); tick();

    // Register 0 as destination and source never interacts
    drive(5'd0, 5'd0, 2'd3, 2'd3, 5'd0, 2'd2, 1'b0, 1'b0, 1'b0);
    expect_o("r0_write", 1'b0, 2'd0, 2'd0, 2'd0, 2'd0, 1'b0); tick();
    drive(5'd0, 5'd0, 2'd0, 2'd0, 5'd4, 2'd1, 1'b0, 1'b0, 1'b0);
    expect_o("r0_read", 1'b0, 2'd0, 2'd0, 2'd0, 2'd0, 1'b0); tick();
    nop();
    expect_o("r0_after", 1'b0, 2'd0, 2'd0, 2'd0, 2'd0, 1'b0); tick();
    expect_o("flush5", 1'b0, 2'd0, 2'd0, 2'd0, 2'd0, 1'b0); tick();

    // div then mflo directly behind it
    drive(5'd0, 5'd0, 2'd3, 2'd3, 5'd0, 2'd0, 1'b1, 1'b1, 1'b1);
    expect_o("div_issue", 1'b0, 2'd0, 2'd0, 2'd0, 2'd0, 1'b0); tick();
    drive(5'd0, 5'd0, 2'd3, 2'd3, 5'd7, 2'd1, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 12; i++) begin
      expect_o($sformatf("div_mflo%0d", i), MD_EN && (i < 11), 2'd0, 2'd0, 2'd0, 2'd0,
               MD_EN && (i < 11));
      tick();
    end
    nop();
    expect_o("div_done", 1'b0, 2'd0, 2'd0, 2'd0, 2'd0, 1'b0); tick();

    // mult then mflo directly behind it
    drive(5'd0, 5'd0, 2'd3, 2'd3, 5'd0, 2'd0, 1'b1, 1'b0, 1'b1);
    expect_o("mult_issue", 1'b0, 2'd0, 2'd0, 2'd0, 2'd0, 1'b0); tick();
    drive(5'd0, 5'd0, 2'd3, 2'd3, 5'd8, 2'd1, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 7; i++) begin
      expect_o($sformatf("mult_mflo%0d", i), MD_EN && (i < 6), 2'd0, 2'd0, 2'd0, 2'd0,
               MD_EN && (i < 6));
      tick();
    end
    nop();
    expect_o("mult_done", 1'b0, 2'd0, 2'd0, 2'd0, 2'd0, 1'b0); tick();

    // Reset in the middle of a mult clears the busy counter
    drive(5'd0, 5'd0, 2'd3, 2'd3, 5'd0, 2'd0, 1'b1, 1'b0, 1'b1);
    expect_o("mult2_issue", 1'b0, 2'd0, 2'd0, 2'd0, 2'd0, 1'b0); tick();
    nop();
    expect_o("mult2_in_e", 1'b0, 2'd0, 2'd0, 2'd0, 2'd0, MD_EN); tick();
    expect_o("mult2_cnt", 1'b0, 2'd0, 2'd0, 2'd0, 2'd0, MD_EN);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    drive(5'd0, 5'd0, 2'd3, 2'd3, 5'd9, 2'd1, 1'b0, 1'b0, 1'b1);
    expect_o("rst_mid_mult", 1'b0, 2'd0, 2'd0, 2'd0, 2'd0, 1'b0); tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
